// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
//   Measures period and high time of an asynchronous switching waveform
//   (looped-back switch-drive PWM or an external gate signal) in system clock
//   cycles. Each completed input cycle is reported with a one-cycle strobe.
//   Lock and timeout status are kept for the supervising control logic.
//
// Ports
//   clk         in   system clock (100 MHz)
//   rst_n       in   asynchronous active-low reset
//   pwm_in      in   asynchronous waveform under measurement
//   period      out  [CNT_W] last measured period, clk cycles
//   high_time   out  [CNT_W] high time of the same input cycle, clk cycles
//   meas_valid  out  one-cycle pulse when period/high_time update
//   in_range    out  last period within [PERIOD_MIN, PERIOD_MAX]
//   lock        out  two consecutive in-range results seen
//   timeout     out  no rising edge for TIMEOUT cycles; sticky until next rise
//
// Build option
//   PWM_CAPTURE_GLITCH_FILTER_EN : when defined, a 3-sample filter follows the
//   synchronizer, rejecting pulses shorter than 3 cycles (+2 cycles latency).
// -----------------------------------------------------------------------------
module pwm_capture #(
    parameter int CNT_W      = 20,
    parameter int PERIOD_MIN = 47000,
    parameter int PERIOD_MAX = 49000,
    parameter int TIMEOUT    = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             in_range,
    output logic             lock,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] PMIN_C    = CNT_W'(PERIOD_MIN);
    localparam logic [CNT_W-1:0] PMAX_C    = CNT_W'(PERIOD_MAX);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MEAS = 1'b1
    } state_t;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_s_prev;
    logic             r_rise;
    logic             r_fall;
    logic [3:0]       r_prime;
    logic             w_s;
    logic             w_primed;
    logic             w_in_range;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hi_cap;
    state_t           r_state;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high_time;
    logic             r_meas_valid;
    logic             r_in_range;
    logic             r_lock;
    logic [1:0]       r_lock_cnt;
    logic             r_timeout;

    // The edge detector stays blind until the synchronizer holds real samples,
    // so a level already present at reset release is not mistaken for an edge.
    assign w_primed = r_prime[3];

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    logic [1:0] r_hist;

    // History of the two previous synchronized samples for the 3-sample filter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= 2'b00;
        end else begin
            r_hist <= {r_hist[0], r_sync2};
        end
    end

    // Filtered level: follow the input only after 3 equal samples, else hold.
    always_comb begin
        w_s = r_s_prev;
        if ((r_sync2 == r_hist[0]) && (r_sync2 == r_hist[1])) begin
            w_s = r_sync2;
        end else begin
            w_s = r_s_prev;
        end
    end
`else
    // Unfiltered level: the raw synchronizer output.
    always_comb begin
        w_s = r_sync2;
    end
`endif

    // Two-flop synchronizer, priming shift register and registered edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_s_prev <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_prime  <= 4'b0000;
        end else begin
            r_sync1 <= pwm_in;
            r_sync2 <= r_sync1;
            r_prime <= {r_prime[2:0], 1'b1};
            if (w_primed) begin
                r_s_prev <= w_s;
                r_rise   <= w_s & ~r_s_prev;
                r_fall   <= ~w_s & r_s_prev;
            end else begin
                r_s_prev <= r_sync2;
                r_rise   <= 1'b0;
                r_fall   <= 1'b0;
            end
        end
    end

    // Cycle counter restarted by each rise, saturating at TIMEOUT; the fall
    // snapshot gives the high time of the cycle in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_hi_cap <= '0;
        end else begin
            if (r_rise) begin
                r_cnt <= ONE_C;
            end else if (r_cnt != TIMEOUT_C) begin
                r_cnt <= r_cnt + ONE_C;
            end else begin
                r_cnt <= r_cnt;
            end
            if (r_fall) begin
                r_hi_cap <= r_cnt;
            end else begin
                r_hi_cap <= r_hi_cap;
            end
        end
    end

    assign w_in_range = (r_cnt >= PMIN_C) && (r_cnt <= PMAX_C);

    // Measurement FSM with registered results, lock tracking and timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_period     <= '0;
            r_high_time  <= '0;
            r_meas_valid <= 1'b0;
            r_in_range   <= 1'b0;
            r_lock       <= 1'b0;
            r_lock_cnt   <= 2'd0;
            r_timeout    <= 1'b0;
        end else begin
            r_meas_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // First rise only arms the block; no complete cycle yet.
                    if (r_rise) begin
                        r_state   <= ST_MEAS;
                        r_timeout <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_MEAS: begin
                    // A rise wins over a simultaneous saturation of the counter.
                    if (r_rise) begin
                        r_period     <= r_cnt;
                        r_high_time  <= r_hi_cap;
                        r_meas_valid <= 1'b1;
                        r_in_range   <= w_in_range;
                        if (w_in_range) begin
                            if (r_lock_cnt != 2'd2) begin
                                r_lock_cnt <= r_lock_cnt + 2'd1;
                            end else begin
                                r_lock_cnt <= r_lock_cnt;
                            end
                            // Count reaches 2 on this result if it was already >= 1.
                            r_lock <= (r_lock_cnt != 2'd0);
                        end else begin
                            r_lock_cnt <= 2'd0;
                            r_lock     <= 1'b0;
                        end
                    end else if (r_cnt == TIMEOUT_C) begin
                        r_timeout  <= 1'b1;
                        r_lock     <= 1'b0;
                        r_lock_cnt <= 2'd0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_state <= ST_MEAS;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign period     = r_period;
    assign high_time  = r_high_time;
    assign meas_valid = r_meas_valid;
    assign in_range   = r_in_range;
    assign lock       = r_lock;
    assign timeout    = r_timeout;

endmodule
